// File: rtl/lsu_bus_bridge.sv
// LSU-to-bus bridge: turns a single-cycle LSU request into a valid/ready bus transaction and stalls the pipeline until it completes.
// Optional BUS_TIMEOUT_EN macro enables an abort counter (TIMEOUT_CYCLES) and the bus_err pulse.
module lsu_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        stall,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_mask,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t state, state_nxt;
    logic   capture;

`ifdef BUS_TIMEOUT_EN
    logic [15:0] cnt;
    logic        timeout;
    logic        err_q;
`endif

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
`ifdef BUS_TIMEOUT_EN
        timeout   = 1'b0;
`endif
        case (state)
            IDLE: if (cs) state_nxt = REQ;
            REQ: begin
                if (bus_ready) begin
                    if (bus_we) begin
                        state_nxt = DONE;
                    end else if (bus_rvalid) begin
                        capture   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef BUS_TIMEOUT_EN
        // Abort only when the cycle did not already complete the transaction.
        if ((state == REQ || state == WAIT) && state_nxt != DONE &&
            cnt >= 16'(TIMEOUT_CYCLES - 1)) begin
            state_nxt = DONE;
            timeout   = 1'b1;
        end
`endif
    end

    assign bus_valid = (state == REQ);
    assign stall     = (state == IDLE && cs) || state == REQ || state == WAIT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            bus_mask  <= 4'h0;
            data_rd   <= 32'h0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cs) begin
                bus_we    <= wr;
                bus_addr  <= addr;
                bus_wdata <= data_wr;
                bus_mask  <= mask;
            end
            if (capture)
                data_rd <= bus_rdata;
`ifdef BUS_TIMEOUT_EN
            else if (timeout && !bus_we)
                data_rd <= 32'h0;
`endif
        end
    end

`ifdef BUS_TIMEOUT_EN
    // Counter is held at zero in IDLE, so it starts from zero on entry to REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= 16'h0;
            err_q <= 1'b0;
        end else begin
            err_q <= timeout;
            if (state == REQ || state == WAIT)
                cnt <= cnt + 16'h1;
            else
                cnt <= 16'h0;
        end
    end

    assign bus_err = err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Scoreboard bench for lsu_bus_bridge: directed stimulus pushes expected bus requests and responses; a negedge monitor pops and compares.
module tb_lsu_bus_bridge;

    logic        clk = 1'b0;
    logic        rst, cs, wr, bus_ready, bus_rvalid;
    logic [3:0]  mask;
    logic [31:0] addr, data_wr, bus_rdata;
    logic [31:0] data_rd, bus_addr, bus_wdata;
    logic        stall, bus_valid, bus_we, bus_err;
    logic [3:0]  bus_mask;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } req_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    lsu_bus_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .cs(cs), .wr(wr), .mask(mask), .addr(addr),
        .data_wr(data_wr), .data_rd(data_rd), .stall(stall),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_mask(bus_mask),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic req_t mk_req(logic w, logic [31:0] a, logic [31:0] d, logic [3:0] m);
        req_t r;
        r.we = w; r.addr = a; r.wdata = d; r.mask = m;
        return r;
    endfunction

    function automatic rsp_t mk_rsp(logic [31:0] d, logic e);
        rsp_t r;
        r.data = d; r.err = e;
        return r;
    endfunction

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        cs = 1'b1; wr = w; addr = a; data_wr = d; mask = m;
    endtask

    // Monitor: bus handshakes are checked against exp_req, pipeline releases against exp_rsp.
    initial begin
        logic prev_stall;
        req_t r;
        rsp_t s;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus_valid && bus_ready) begin
                    if (exp_req.size() == 0) begin
                        chk("unexpected_handshake", 32'h1, 32'h0);
                    end else begin
                        r = exp_req.pop_front();
                        chk("req_we",    {31'h0, bus_we}, {31'h0, r.we});
                        chk("req_addr",  bus_addr,  r.addr);
                        chk("req_wdata", bus_wdata, r.wdata);
                        chk("req_mask",  {28'h0, bus_mask}, {28'h0, r.mask});
                    end
                end
                if (prev_stall && !stall) begin
                    if (exp_rsp.size() == 0) begin
                        chk("unexpected_release", 32'h1, 32'h0);
                    end else begin
                        s = exp_rsp.pop_front();
                        chk("rsp_data_rd", data_rd, s.data);
                        chk("rsp_bus_err", {31'h0, bus_err}, {31'h0, s.err});
                    end
                end
            end
            prev_stall = stall;
        end
    end

    initial begin
        rst = 1'b1; cs = 1'b0; wr = 1'b0; mask = 4'h0; addr = 32'h0; data_wr = 32'h0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        repeat (2) tick();
        chk("rst_bus_valid", {31'h0, bus_valid}, 32'h0);
        chk("rst_stall",     {31'h0, stall},     32'h0);
        chk("rst_bus_we",    {31'h0, bus_we},    32'h0);
        chk("rst_bus_err",   {31'h0, bus_err},   32'h0);
        chk("rst_data_rd",   data_rd,   32'h0);
        chk("rst_bus_addr",  bus_addr,  32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_mask",  {28'h0, bus_mask}, 32'h0);
        rst = 1'b0;

        // Store, slave not ready for two cycles
        tick();
        issue(1'b1, 32'h100, 32'hA5A5_0001, 4'hF);
        exp_req.push_back(mk_req(1'b1, 32'h100, 32'hA5A5_0001, 4'hF));
        exp_rsp.push_back(mk_rsp(32'h0, 1'b0));
        #1;
        chk("st_c0_stall", {31'h0, stall},     32'h1);
        chk("st_c0_valid", {31'h0, bus_valid}, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            bus_ready = (c == 3);
            #1;
            chk("st_stall", {31'h0, stall},     32'h1);
            chk("st_valid", {31'h0, bus_valid}, 32'h1);
            chk("st_addr",  bus_addr,  32'h100);
            chk("st_wdata", bus_wdata, 32'hA5A5_0001);
        end
        tick();
        bus_ready = 1'b0;
        #1;
        chk("st_done_stall", {31'h0, stall},     32'h0);
        chk("st_done_valid", {31'h0, bus_valid}, 32'h0);
        tick();
        cs = 1'b0;

        // Load, split response in cycle 4
        tick();
        issue(1'b0, 32'h200, 32'h0, 4'h3);
        exp_req.push_back(mk_req(1'b0, 32'h200, 32'h0, 4'h3));
        exp_rsp.push_back(mk_rsp(32'h1234_5678, 1'b0));
        tick();
        bus_ready = 1'b1;
        #1;
        chk("ld_c1_valid", {31'h0, bus_valid}, 32'h1);
        for (int c = 2; c <= 4; c++) begin
            tick();
            bus_ready = 1'b0;
            if (c == 4) begin
                bus_rvalid = 1'b1;
                bus_rdata  = 32'h1234_5678;
            end
            #1;
            chk("ld_wait_valid", {31'h0, bus_valid}, 32'h0);
            chk("ld_wait_stall", {31'h0, stall},     32'h1);
        end
        tick();
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;
        #1;
        chk("ld_c5_stall",   {31'h0, stall}, 32'h0);
        chk("ld_c5_data_rd", data_rd, 32'h1234_5678);
        tick();
        cs = 1'b0;

        // Load, same-cycle response
        tick();
        issue(1'b0, 32'h304, 32'h0, 4'hC);
        exp_req.push_back(mk_req(1'b0, 32'h304, 32'h0, 4'hC));
        exp_rsp.push_back(mk_rsp(32'hCAFE_F00D, 1'b0));
        tick();
        bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
        #1;
        chk("sc_c1_valid", {31'h0, bus_valid}, 32'h1);
        tick();
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        #1;
        chk("sc_c2_stall",   {31'h0, stall}, 32'h0);
        chk("sc_c2_data_rd", data_rd, 32'hCAFE_F00D);
        tick();
        cs = 1'b0;

        // Back-to-back store then load, zero-wait slave
        tick();
        bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_BEEF;
        issue(1'b1, 32'h400, 32'h1111_2222, 4'h1);
        exp_req.push_back(mk_req(1'b1, 32'h400, 32'h1111_2222, 4'h1));
        exp_rsp.push_back(mk_rsp(32'hCAFE_F00D, 1'b0));
        tick();
        #1 chk("b2b_c1_valid", {31'h0, bus_valid}, 32'h1);
        tick();
        #1 chk("b2b_c2_valid", {31'h0, bus_valid}, 32'h0);
        chk("b2b_c2_stall", {31'h0, stall}, 32'h0);
        tick();
        issue(1'b0, 32'h404, 32'h0, 4'hF);
        exp_req.push_back(mk_req(1'b0, 32'h404, 32'h0, 4'hF));
        exp_rsp.push_back(mk_rsp(32'h0BAD_BEEF, 1'b0));
        #1 chk("b2b_c3_valid", {31'h0, bus_valid}, 32'h0);
        chk("b2b_c3_stall", {31'h0, stall}, 32'h1);
        tick();
        #1 chk("b2b_c4_valid", {31'h0, bus_valid}, 32'h1);
        tick();
        #1 chk("b2b_c5_stall", {31'h0, stall}, 32'h0);
        tick();
        cs = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;

        // Reset while in WAIT, late rvalid afterwards
        tick();
        issue(1'b0, 32'h600, 32'h0, 4'hF);
        exp_req.push_back(mk_req(1'b0, 32'h600, 32'h0, 4'hF));
        exp_rsp.push_back(mk_rsp(32'h0, 1'b0));
        tick();
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0; rst = 1'b1; cs = 1'b0;
        #1 chk("rw_c2_stall", {31'h0, stall}, 32'h1);
        tick();
        rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        #1 chk("rw_c3_valid", {31'h0, bus_valid}, 32'h0);
        chk("rw_c3_stall",   {31'h0, stall}, 32'h0);
        chk("rw_c3_data_rd", data_rd, 32'h0);
        tick();
        bus_rvalid = 1'b0; bus_rdata = 32'h0;
        #1 chk("rw_c4_data_rd", data_rd, 32'h0);
        chk("rw_c4_valid", {31'h0, bus_valid}, 32'h0);

`ifdef BUS_TIMEOUT_EN
        // Preload nonzero data so the timeout clear is visible
        tick();
        issue(1'b0, 32'h700, 32'h0, 4'hF);
        exp_req.push_back(mk_req(1'b0, 32'h700, 32'h0, 4'hF));
        exp_rsp.push_back(mk_rsp(32'h5555_AAAA, 1'b0));
        tick();
        bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
        tick();
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        tick();
        cs = 1'b0;

        // Timeout: slave never ready
        tick();
        issue(1'b0, 32'h500, 32'h0, 4'hF);
        exp_rsp.push_back(mk_rsp(32'h0, 1'b1));
        for (int c = 1; c <= 16; c++) begin
            tick();
            #1;
            chk("to_stall", {31'h0, stall},     32'h1);
            chk("to_valid", {31'h0, bus_valid}, 32'h1);
            chk("to_err",   {31'h0, bus_err},   32'h0);
        end
        tick();
        #1 chk("to_c17_stall", {31'h0, stall},   32'h0);
        chk("to_c17_err",     {31'h0, bus_err}, 32'h1);
        chk("to_c17_data_rd", data_rd, 32'h0);
        tick();
        cs = 1'b0;
        #1 chk("to_c18_err", {31'h0, bus_err}, 32'h0);
`endif

        repeat (3) tick();
        chk("sb_req_drained", exp_req.size(), 32'h0);
        chk("sb_rsp_drained", exp_rsp.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
